// File: rtl/shade_stage_pkg.sv
// Shared types and constants for the shade stage: FSM states, pixel format,
// and where the normal sits inside a triangle record.
package shade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEMWAIT,
    CALC,
    EMIT
  } state_e;

  localparam int unsigned PIX_BITS    = 8;
  localparam int unsigned PIX_MAX     = 255;
  localparam int unsigned NORMAL_WORD = 9;

endpackage

// File: rtl/shade_stage_dot3_q.sv
// Combinational signed three-term Q-format dot product, shifted back to Q
// and clamped to [0, 1.0].
module dot3_q #(
  parameter int unsigned W = 32,
  parameter int unsigned Q = 10
) (
  input  logic [2:0][W-1:0] a,
  input  logic [2:0][W-1:0] b,
  output logic [Q:0]        y
);

  localparam logic signed [2*W+1:0] ONE_S = (2*W+2)'(1) << Q;
  localparam logic        [Q:0]     ONE   = (Q+1)'(1) << Q;

  logic signed [2*W-1:0] prod [3];
  logic signed [2*W+1:0] sum;
  logic signed [2*W+1:0] shifted;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      prod[i] = $signed({{W{a[i][W-1]}}, a[i]}) * $signed({{W{b[i][W-1]}}, b[i]});
    end
    sum = {{2{prod[0][2*W-1]}}, prod[0]}
        + {{2{prod[1][2*W-1]}}, prod[1]}
        + {{2{prod[2][2*W-1]}}, prod[2]};
    shifted = sum >>> Q;
    if (shifted[2*W+1]) begin
      y = '0;
    end else if (shifted > ONE_S) begin
      y = ONE;
    end else begin
      y = shifted[Q:0];
    end
  end

endmodule

// File: rtl/shade_stage.sv
// Final pipeline stage: Lambertian shading of the nearest hit into an 8-bit
// raster pixel. Define SHADER_AMBIENT_EN to add a constant ambient term.
module shade_stage
  import shade_pkg::*;
#(
  parameter int unsigned D_BITS    = 32,
  parameter int unsigned Q_BITS    = 10,
  parameter int unsigned M_BITS    = 12,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter logic [7:0]  BG_COLOR  = 8'd32,
  parameter int unsigned AMBIENT_Q = 102
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_wr_en,
  output logic                         in_full,
  input  logic                         hit,
  input  logic [2:0][D_BITS-1:0]       p_hit,
  input  logic [M_BITS-1:0]            triangle_ID,
  input  logic [2:0][D_BITS-1:0]       light_dir,
  output logic [M_BITS-1:0]            mem_addr,
  input  logic [11:0][D_BITS-1:0]      mem_data,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic [7:0]                   pixel_out,
  output logic [$clog2(IMG_W)-1:0]     pixel_x,
  output logic [$clog2(IMG_H)-1:0]     pixel_y,
  output logic                         frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  state_e                  state_q, state_d;
  logic [M_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [2:0][D_BITS-1:0]  normal_q, normal_d;
  logic [PIX_BITS-1:0]     pixel_q, pixel_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;

  logic [Q_BITS:0]         diffuse;
  logic [Q_BITS:0]         intensity;
  logic [PIX_BITS-1:0]     shade_pix;
  logic                    last_px;

  dot3_q #(
    .W (D_BITS),
    .Q (Q_BITS)
  ) u_dot3 (
    .a (normal_q),
    .b (light_dir),
    .y (diffuse)
  );

`ifdef SHADER_AMBIENT_EN
  localparam logic [Q_BITS+1:0] ONE_A = (Q_BITS+2)'(1) << Q_BITS;
  logic [Q_BITS+1:0] lit_sum;
  assign lit_sum   = {1'b0, diffuse} + (Q_BITS+2)'(AMBIENT_Q);
  assign intensity = (lit_sum > ONE_A) ? ONE_A[Q_BITS:0] : lit_sum[Q_BITS:0];
  logic unused_bits;
  assign unused_bits = ^{p_hit, mem_data[NORMAL_WORD-1:0]};
`else
  assign intensity = diffuse;
  logic unused_bits;
  assign unused_bits = ^{p_hit, mem_data[NORMAL_WORD-1:0], 32'(AMBIENT_Q)};
`endif

  assign shade_pix = PIX_BITS'((32'(intensity) * 32'(PIX_MAX)) >> Q_BITS);
  assign last_px   = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    normal_d   = normal_q;
    pixel_d    = pixel_q;
    x_d        = x_q;
    y_d        = y_q;
    out_wr_en  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_wr_en) begin
          // The address register doubles as the captured ID so the read is
          // already in flight during FETCH.
          if (hit) begin
            mem_addr_d = triangle_ID;
            state_d    = FETCH;
          end else begin
            pixel_d = BG_COLOR;
            state_d = EMIT;
          end
        end
      end
      FETCH:   state_d = MEMWAIT;
      MEMWAIT: begin
        normal_d = mem_data[NORMAL_WORD+2:NORMAL_WORD];
        state_d  = CALC;
      end
      CALC: begin
        pixel_d = shade_pix;
        state_d = EMIT;
      end
      EMIT: begin
        if (!out_full) begin
          out_wr_en  = 1'b1;
          frame_done = last_px;
          state_d    = IDLE;
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      normal_q   <= '0;
      pixel_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      normal_q   <= normal_d;
      pixel_q    <= pixel_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign in_full   = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign pixel_out = pixel_q;
  assign pixel_x   = x_q;
  assign pixel_y   = y_q;

endmodule

// File: tb/tb_shade_stage.sv
// Directed self-checking bench for shade_stage on a 4x2 raster.
module tb_shade_stage;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_wr_en;
  logic               in_full;
  logic               hit;
  logic [2:0][31:0]   p_hit;
  logic [11:0]        triangle_ID;
  logic [2:0][31:0]   light_dir;
  logic [11:0]        mem_addr;
  logic [11:0][31:0]  mem_data;
  logic               out_full;
  logic               out_wr_en;
  logic [7:0]         pixel_out;
  logic [1:0]         pixel_x;
  logic [0:0]         pixel_y;
  logic               frame_done;

  int tests = 0;
  int fails = 0;
  int wcount = 0;

  shade_stage #(
    .D_BITS   (32),
    .Q_BITS   (10),
    .M_BITS   (12),
    .IMG_W    (4),
    .IMG_H    (2),
    .BG_COLOR (8'd32),
    .AMBIENT_Q(102)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_wr_en   (in_wr_en),
    .in_full    (in_full),
    .hit        (hit),
    .p_hit      (p_hit),
    .triangle_ID(triangle_ID),
    .light_dir  (light_dir),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .pixel_out  (pixel_out),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Triangle memory: one-cycle registered read; normal at words 9..11 (x,y,z).
  function automatic logic [11:0][31:0] rec(input logic [11:0] a);
    rec = '0;
    rec[0] = 32'hDEAD_BEEF;
    case (a)
      12'd5: rec[11] = 32'd1024;
      12'd9: begin rec[9] = 32'd600; rec[11] = 32'd800; end
      default: ;
    endcase
  endfunction

  always @(posedge clock) mem_data <= rec(mem_addr);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ray(input logic h, input logic [11:0] id);
    in_wr_en    = 1'b1;
    hit         = h;
    triangle_ID = id;
    tick();
    in_wr_en    = 1'b0;
  endtask

  // Called in the first cycle after capture; waits (bounded) for the write.
  task automatic wait_write(input string tag, input logic [7:0] pix, input int exp_lat);
    int lat = 1;
    while (!out_wr_en && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_wr"},    32'(out_wr_en), 32'd1);
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_pix"},   32'(pixel_out), 32'(pix));
    chk({tag, "_x"},     32'(pixel_x), 32'(wcount % 4));
    chk({tag, "_y"},     32'(pixel_y), 32'((wcount / 4) % 2));
    chk({tag, "_frame"}, 32'(frame_done), 32'(wcount % 8 == 7));
    tick();
    wcount++;
  endtask

  initial begin
    reset       = 1'b0;
    in_wr_en    = 1'b0;
    hit         = 1'b0;
    triangle_ID = '0;
    out_full    = 1'b0;
    p_hit       = {32'd7, 32'd8, 32'd9};
    light_dir   = {32'd1024, 32'd0, 32'd0};
    tick();
    tick();
    chk("rst_in_full", 32'(in_full), 32'd0);
    chk("rst_wr",      32'(out_wr_en), 32'd0);
    chk("rst_frame",   32'(frame_done), 32'd0);
    chk("rst_pix",     32'(pixel_out), 32'd0);
    chk("rst_addr",    32'(mem_addr), 32'd0);
    chk("rst_x",       32'(pixel_x), 32'd0);
    chk("rst_y",       32'(pixel_y), 32'd0);
    reset = 1'b1;
    tick();

    // Facing light head-on
    ray(1'b1, 12'd5);
    chk("h1_in_full", 32'(in_full), 32'd1);
    chk("h1_addr",    32'(mem_addr), 32'd5);
    wait_write("h1", 8'd255, 4);
    chk("h1_idle", 32'(in_full), 32'd0);

    light_dir = {32'd512, 32'd0, 32'd0};
    ray(1'b1, 12'd5);
    wait_write("half", 8'd127, 4);

    light_dir = {-32'sd1024, 32'd0, 32'd0};
    ray(1'b1, 12'd5);
`ifdef SHADER_AMBIENT_EN
    wait_write("back", 8'd25, 4);
`else
    wait_write("back", 8'd0, 4);
`endif

    // x and z terms summed: 600*600 + 800*800 = 1e6 -> 976 -> 243
    light_dir = {32'd800, 32'd0, 32'd600};
    ray(1'b1, 12'd9);
`ifdef SHADER_AMBIENT_EN
    wait_write("mix", 8'd255, 4);
`else
    wait_write("mix", 8'd243, 4);
`endif

    // Miss: background, no memory access
    ray(1'b0, 12'd100);
    chk("miss_in_full", 32'(in_full), 32'd1);
    chk("miss_addr",    32'(mem_addr), 32'd9);
    wait_write("miss", 8'd32, 1);
    chk("miss_in_full_after", 32'(in_full), 32'd0);

    // Backpressure during EMIT, with a stray write that must be ignored
    light_dir = {32'd1024, 32'd0, 32'd0};
    ray(1'b1, 12'd5);
    out_full = 1'b1;
    tick();
    tick();
    tick();
    in_wr_en = 1'b1;
    hit      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wr",      32'(out_wr_en), 32'd0);
      chk("bp_pix",     32'(pixel_out), 32'd255);
      chk("bp_in_full", 32'(in_full), 32'd1);
      chk("bp_x",       32'(pixel_x), 32'd1);
      chk("bp_y",       32'(pixel_y), 32'd1);
      tick();
    end
    in_wr_en = 1'b0;
    out_full = 1'b0;
    #1;
    wait_write("bp", 8'd255, 1);
    chk("bp_idle", 32'(in_full), 32'd0);
    tick();
    chk("bp_no_phantom_wr",   32'(out_wr_en), 32'd0);
    chk("bp_no_phantom_full", 32'(in_full), 32'd0);

    // Reset in MEMWAIT abandons the ray
    ray(1'b1, 12'd5);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wcount = 0;
    chk("mr_in_full", 32'(in_full), 32'd0);
    chk("mr_wr",      32'(out_wr_en), 32'd0);
    chk("mr_x",       32'(pixel_x), 32'd0);
    chk("mr_y",       32'(pixel_y), 32'd0);
    chk("mr_addr",    32'(mem_addr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("mr_quiet", 32'(out_wr_en), 32'd0);
      tick();
    end
    ray(1'b1, 12'd5);
    wait_write("mr_next", 8'd255, 4);

    // Full frame of misses from a clean raster
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wcount = 0;
    for (int i = 0; i < 9; i++) begin
      ray(1'b0, 12'(i));
      wait_write("frm", 8'd32, 1);
    end
    chk("frm_wrap_x", 32'(pixel_x), 32'd1);
    chk("frm_wrap_y", 32'(pixel_y), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
